// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port and serial-side status of the buffered UART transmitter
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 en;
  logic [DATA_BITS-1:0] data;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 tx;
  logic                 busy;
  logic                 done;
  modport master (output en, data, input full, empty, overflow, tx, busy, done);
  modport slave  (input en, data, output full, empty, overflow, tx, busy, done);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small word FIFO, frames sent back to back
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input logic           CP,
  input logic           RST,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        rd_q, wr_q;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 full_q, empty_q, ovf_q;
  state_t               st_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] sh_q, head;
  logic                 par_q, tx_q, busy_q, done_q;
  logic                 push, pop, last_baud, last_stop;
  assign head      = mem_q[rd_q];
  assign push      = bus.en & ~full_q;
  assign last_baud = baud_q == BW'(CLKS_PER_BIT - 1);
  assign last_stop = bit_q == 4'(STOP_BITS - 1);
  assign pop       = ~empty_q & ((st_q == IDLE) | ((st_q == STOP) & last_baud & last_stop));
  assign cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = ovf_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  // FIFO storage; stale contents are harmless because the pointers are cleared on reset
  always_ff @(posedge CP)
    if (push) mem_q[wr_q] <= bus.data;
  // FIFO pointers, exact registered full/empty and the overflow pulse
  always_ff @(posedge CP or negedge RST)
    if (!RST) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= cnt_d == '0;
      ovf_q   <= bus.en & full_q;
    end
  // Frame sequencer; a pop at IDLE or at the last stop cycle starts the next frame with no gap
  always_ff @(posedge CP or negedge RST)
    if (!RST) begin
      st_q   <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        START:
          if (last_baud) begin
            st_q   <= DATA;
            baud_q <= '0;
            bit_q  <= '0;
            tx_q   <= sh_q[0];
          end else baud_q <= baud_q + 1'b1;
        DATA:
          if (last_baud) begin
            baud_q <= '0;
            if (bit_q == 4'(DATA_BITS - 1)) begin
              bit_q <= '0;
              st_q  <= PARITY != 0 ? PAR : STOP;
              tx_q  <= PARITY != 0 ? par_q : 1'b1;
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= sh_q >> 1;
              tx_q  <= sh_q[1];
            end
          end else baud_q <= baud_q + 1'b1;
        PAR:
          if (last_baud) begin
            st_q   <= STOP;
            baud_q <= '0;
            bit_q  <= '0;
            tx_q   <= 1'b1;
          end else baud_q <= baud_q + 1'b1;
        STOP:
          if (last_baud) begin
            baud_q <= '0;
            if (last_stop) begin
              bit_q <= '0;
              if (!pop) begin
                st_q   <= IDLE;
                busy_q <= 1'b0;
              end
            end else bit_q <= bit_q + 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
            done_q <= last_stop & (baud_q == BW'(CLKS_PER_BIT - 2));
          end
        default: st_q <= IDLE;
      endcase
      if (pop) begin
        st_q   <= START;
        sh_q   <= head;
        par_q  <= PARITY == 1 ? ~^head : ^head;
        tx_q   <= 1'b0;
        busy_q <= 1'b1;
        baud_q <= '0;
        bit_q  <= '0;
      end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an input FIFO. Next generation of the team's single-byte UART test path.
- Adds configurable data width, parity mode, stop-bit count, baud divisor and buffered back-to-back transmission.
- Sits between the host-side byte producer and the serial pin. Its output feeds the existing receiver in loopback benches.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- CLKS_PER_BIT, 16, CP cycles per serial bit (>= 2)
- DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
- CP  in  1  clock, rising edge
- RST  in  1  asynchronous active-low reset
- en  in  1  write strobe; pushes data when full = 0
- data  in  DATA_BITS  word to transmit
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- overflow  out  1  one-cycle pulse when en = 1 while full = 1
- tx  out  1  serial line, idle high
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (RST = 0, asynchronous): FIFO cleared, FSM in IDLE, bit and baud counters zero.
  - Output values: tx = 1, busy = 0, done = 0, overflow = 0, full = 0, empty = 1.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately; no done pulse.
- FIFO:
  - Write when en = 1 and full = 0, sampled on the CP edge.
  - full and empty are registered and exact.
  - en while full: word dropped, overflow pulses for one cycle, FIFO unchanged. Applies even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE -> START when empty = 0. The head word is popped into the shift register on that edge.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
  - PARITY: present only if PARITY != 0. Odd mode: bit = ~^word. Even mode: bit = ^word.
  - STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT cycles.
  - End of STOP: done pulses for one cycle on the last STOP cycle.
  - On that same edge: -> START with a pop if empty = 0 (no idle gap between frames), else -> IDLE.
- Latency:
  - Write at edge k into an empty FIFO with FSM idle: empty = 0 after edge k.
  - FSM enters START at edge k+1, so tx falls after edge k+1.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- busy = 1 from START entry through the last STOP cycle.
- tx is registered; no combinational path from inputs to tx.
- Stable idle: with an empty FIFO, tx holds 1 indefinitely.

Test Plan:
- Setup for all scenarios: CLKS_PER_BIT = 4, DATA_BITS = 8.
- Basic frame, PARITY = 0, STOP_BITS = 1: write 42 (0x2A) once.
  -> tx sequence: start 0, then 0,1,0,1,0,1,0,0, then stop 1; each bit 4 cycles.
  -> done pulses once 40 cycles after tx falls; busy then drops.
- Parity, PARITY = 2 (even): write 42, then 23.
  -> parity bit 1 for 42 (three ones), parity bit 0 for 23 (four ones); frame 44 cycles each.
  -> Repeat with PARITY = 1 (odd): parity bits 0 and 1.
- Back-to-back, DEPTH = 4: write 1, 2, 3, 4 on consecutive cycles.
  -> full = 1 after the 4th write cycle only if the first pop has not yet occurred; otherwise full stays 0.
  -> four frames with no idle cycles between the stop of one and the start of the next.
  -> four done pulses, 40 cycles apart; empty = 1 after the 4th pop.
- Overflow: hold tx busy and write 6 words.
  -> overflow pulses for each write while full = 1.
  -> dropped words are never transmitted; the transmitted sequence matches accepted words in order.
- Reset mid-frame: assert RST = 0 during a DATA bit of word 42.
  -> tx = 1, busy = 0, empty = 1 asynchronously; no done pulse.
  -> after release, writing 23 yields a clean frame.
- STOP_BITS = 2: write 23.
  -> stop high for 8 cycles; done pulses on the 8th stop cycle; frame 44 cycles.
